// File: rtl/isr_unit_pkg.sv
// Shared definitions for the in-service register unit.
// Holds the IR count, the index width and the fixed-priority lowest-set-bit helper.
// Pure declarations; no timing or flow control involved.
package isr_unit_pkg;

  localparam int IR_COUNT = 8;
  localparam int IDX_W    = 3;

  typedef logic [IR_COUNT-1:0] ir_vec_t;
  typedef logic [IDX_W-1:0]    ir_idx_t;

  // Index of the lowest-numbered set bit (IR0 has highest priority); 0 when v is empty.
  function automatic ir_idx_t lowest_set_idx(input ir_vec_t v);
    ir_idx_t idx;
    idx = '0;
    for (int i = IR_COUNT - 1; i >= 0; i--) begin
      if (v[i]) idx = ir_idx_t'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/pic_edge_detect.sv
// 1-bit rising-edge detector for the INTA pulses.
// Latency: rise is combinational from din against the registered history.
// Backpressure: none; a level held high yields one rise per pulse.
module pic_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  // History is "input was seen low last cycle"; it is cleared by reset so a
  // pulse already high when reset releases is never mistaken for a new edge.
  logic was_low;

  // Track whether the previous sample was low.
  always_ff @(posedge clk) begin
    if (rst) was_low <= 1'b0;
    else     was_low <= ~din;
  end

  assign rise = din & was_low & ~rst;

endmodule

// File: rtl/isr_unit.sv
// In-service register: sets on INTA#1 edge, clears on AEOI INTA#2 edge or OCW2 EOI.
// Latency: one clk from event to registered outputs; no input-to-output comb path.
// Backpressure: none; every qualifying edge or EOI strobe is acted on immediately.
module isr_unit
  import isr_unit_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] highest_priority_idx,
  input  logic             AEOI,
  input  logic             specific_eoi_flag,
  input  logic [IDX_W-1:0] specific_irq,
  input  logic             eoi_cmd,
  input  logic             ack1,
  input  logic             ack2,
  input  logic             SP,
  input  logic             SNGL,
  output logic [IR_COUNT-1:0] interrupts_in_service,
  output logic [IDX_W-1:0]    last_serviced_idx
);

  logic    ack1_rise;
  logic    ack2_rise;
  ir_vec_t clr_mask;
  ir_vec_t set_mask;
  ir_vec_t isr_next;

  // Cascade role does not change how the ISR is set or cleared.
  logic unused_mode;
  assign unused_mode = SP ^ SNGL;

  pic_edge_detect u_ack1_edge (
    .clk  (clk),
    .rst  (rst),
    .din  (ack1),
    .rise (ack1_rise)
  );

  pic_edge_detect u_ack2_edge (
    .clk  (clk),
    .rst  (rst),
    .din  (ack2),
    .rise (ack2_rise)
  );

  // Clears are all derived from the current ISR; the set is OR-ed last so it wins.
  always_comb begin
    clr_mask = '0;
    set_mask = '0;
    if (ack2_rise && AEOI) clr_mask[last_serviced_idx] = 1'b1;
    if (eoi_cmd) begin
      if (specific_eoi_flag)               clr_mask[specific_irq] = 1'b1;
      else if (|interrupts_in_service)     clr_mask[lowest_set_idx(interrupts_in_service)] = 1'b1;
    end
    if (ack1_rise) set_mask[highest_priority_idx] = 1'b1;
    isr_next = (interrupts_in_service & ~clr_mask) | set_mask;
  end

  // Register ISR and the index captured at the INTA#1 edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      interrupts_in_service <= '0;
      last_serviced_idx     <= '0;
    end else begin
      interrupts_in_service <= isr_next;
      if (ack1_rise) last_serviced_idx <= highest_priority_idx;
    end
  end

endmodule

// File: tb/tb_isr_unit.sv
// Self-checking bench for isr_unit: directed scenarios plus a randomized run against a model.
// Expected states are queued as stimulus is applied and compared one cycle later.
// Inputs change and outputs are sampled 1 time unit after the rising edge.
module tb_isr_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] hpi;
  logic       aeoi;
  logic       spec_flag;
  logic [2:0] spec_irq;
  logic       eoi;
  logic       ack1;
  logic       ack2;
  logic       sp;
  logic       sngl;
  logic [7:0] isr;
  logic [2:0] last;

  typedef struct packed {
    logic [7:0] isr;
    logic [2:0] idx;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state for the randomized section.
  logic [7:0] m_isr;
  logic [2:0] m_last;
  logic       m_p1;
  logic       m_p2;

  isr_unit dut (
    .clk                   (clk),
    .rst                   (rst),
    .highest_priority_idx  (hpi),
    .AEOI                  (aeoi),
    .specific_eoi_flag     (spec_flag),
    .specific_irq          (spec_irq),
    .eoi_cmd               (eoi),
    .ack1                  (ack1),
    .ack2                  (ack2),
    .SP                    (sp),
    .SNGL                  (sngl),
    .interrupts_in_service (isr),
    .last_serviced_idx     (last)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Queue the expected post-edge state, clock once, then pop and compare.
  task automatic cyc(input string tag, input logic [7:0] e_isr, input logic [2:0] e_idx);
    exp_t e;
    sb.push_back('{isr: e_isr, idx: e_idx});
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check_eq({tag, "/sb_empty"}, 8'h01, 8'h00);
    end else begin
      e = sb.pop_front();
      check_eq({tag, "/isr"}, isr, e.isr);
      check_eq({tag, "/idx"}, {5'b0, last}, {5'b0, e.idx});
    end
  endtask

  // Non-AEOI pulse pair at index ia, clear it, then AEOI pulse pair at index ib.
  task automatic run_pair(input string tag, input logic [2:0] ia, input logic [2:0] ib);
    logic [7:0] oh_a;
    logic [7:0] oh_b;
    oh_a = 8'd1 << ia;
    oh_b = 8'd1 << ib;
    aeoi = 1'b0; hpi = ia; ack1 = 1'b1;
    cyc({tag, "_a1"}, oh_a, ia);
    hpi = ia ^ 3'd7;
    cyc({tag, "_a1hold1"}, oh_a, ia);
    cyc({tag, "_a1hold2"}, oh_a, ia);
    ack1 = 1'b0;
    cyc({tag, "_a1low"}, oh_a, ia);
    ack2 = 1'b1;
    cyc({tag, "_a2noaeoi"}, oh_a, ia);
    cyc({tag, "_a2hold"}, oh_a, ia);
    ack2 = 1'b0;
    cyc({tag, "_a2low"}, oh_a, ia);
    eoi = 1'b1; spec_flag = 1'b1; spec_irq = ia;
    cyc({tag, "_clr"}, 8'h00, ia);
    eoi = 1'b0; spec_flag = 1'b0;
    aeoi = 1'b1; hpi = ib; ack1 = 1'b1;
    cyc({tag, "_aeoi_a1"}, oh_b, ib);
    ack1 = 1'b0;
    cyc({tag, "_aeoi_a1low"}, oh_b, ib);
    ack2 = 1'b1;
    cyc({tag, "_aeoi_a2"}, 8'h00, ib);
    cyc({tag, "_aeoi_a2hold"}, 8'h00, ib);
    ack2 = 1'b0; aeoi = 1'b0;
    cyc({tag, "_aeoi_end"}, 8'h00, ib);
  endtask

  initial begin
    logic [7:0] nxt;
    bit         r1;
    bit         r2;
    rst = 1'b1; hpi = 3'd0; aeoi = 1'b0; spec_flag = 1'b0; spec_irq = 3'd0;
    eoi = 1'b0; ack1 = 1'b0; ack2 = 1'b0; sp = 1'b0; sngl = 1'b1;
    #1;
    cyc("rst0", 8'h00, 3'd0);
    cyc("rst1", 8'h00, 3'd0);
    rst = 1'b0;
    cyc("idle0", 8'h00, 3'd0);
    cyc("idle1", 8'h00, 3'd0);

    // Build ISR = 00010100 then non-specific and specific EOI.
    hpi = 3'd2; ack1 = 1'b1; cyc("set2", 8'h04, 3'd2);
    ack1 = 1'b0;             cyc("set2low", 8'h04, 3'd2);
    hpi = 3'd4; ack1 = 1'b1; cyc("set4", 8'h14, 3'd4);
    ack1 = 1'b0;             cyc("set4low", 8'h14, 3'd4);
    eoi = 1'b1; spec_flag = 1'b0;
    cyc("ns_eoi", 8'h10, 3'd4);
    spec_flag = 1'b1; spec_irq = 3'd4;
    cyc("sp_eoi4", 8'h00, 3'd4);
    spec_flag = 1'b0;
    cyc("ns_eoi_empty", 8'h00, 3'd4);
    spec_flag = 1'b1; spec_irq = 3'd6;
    cyc("sp_eoi_unset", 8'h00, 3'd4);
    eoi = 1'b0; spec_flag = 1'b0;

    // Same behaviour in single, cascade slave and cascade master.
    sngl = 1'b1; sp = 1'b0; run_pair("single", 3'd3, 3'd1);
    sngl = 1'b0; sp = 1'b0; run_pair("slave", 3'd2, 3'd4);
    sngl = 1'b0; sp = 1'b1; run_pair("master", 3'd2, 3'd4);
    sngl = 1'b1; sp = 1'b0;

    // Set and clear of the same bit in one cycle: set wins.
    hpi = 3'd2; ack1 = 1'b1; cyc("pre2", 8'h04, 3'd2);
    ack1 = 1'b0;             cyc("pre2low", 8'h04, 3'd2);
    ack1 = 1'b1; eoi = 1'b1; spec_flag = 1'b1; spec_irq = 3'd2;
    cyc("set_wins", 8'h04, 3'd2);
    ack1 = 1'b0; eoi = 1'b0; spec_flag = 1'b0;
    cyc("set_wins_low", 8'h04, 3'd2);
    // Different bits in one cycle: non-specific clears IR2, set lands on IR5.
    hpi = 3'd5; ack1 = 1'b1; eoi = 1'b1;
    cyc("set_clr_diff", 8'h20, 3'd5);
    ack1 = 1'b0; eoi = 1'b0;
    cyc("set_clr_diff_low", 8'h20, 3'd5);

    // Reset in the middle of an ack1 pulse; no set after release.
    hpi = 3'd6; ack1 = 1'b1; cyc("pre_rst", 8'h60, 3'd6);
    rst = 1'b1;              cyc("mid_rst", 8'h00, 3'd0);
    rst = 1'b0;              cyc("post_rst0", 8'h00, 3'd0);
    cyc("post_rst1", 8'h00, 3'd0);
    ack1 = 1'b0;             cyc("post_rst_low", 8'h00, 3'd0);

    // ack2 acting on the held last_serviced_idx.
    hpi = 3'd7; ack1 = 1'b1; cyc("set7", 8'h80, 3'd7);
    ack1 = 1'b0; hpi = 3'd1; cyc("set7low", 8'h80, 3'd7);
    aeoi = 1'b1; ack2 = 1'b1; cyc("a2_last", 8'h00, 3'd7);
    ack2 = 1'b0; aeoi = 1'b0; cyc("a2_last_low", 8'h00, 3'd7);

    // Randomized run against an independent behavioural model.
    for (int c = 0; c < 400; c++) begin
      rst       = (c == 0) || ($urandom_range(0, 59) == 0);
      hpi       = 3'($urandom_range(0, 7));
      aeoi      = 1'($urandom_range(0, 1));
      spec_flag = 1'($urandom_range(0, 1));
      spec_irq  = 3'($urandom_range(0, 7));
      eoi       = ($urandom_range(0, 3) == 0);
      ack1      = 1'($urandom_range(0, 1));
      ack2      = 1'($urandom_range(0, 1));
      sp        = 1'($urandom_range(0, 1));
      sngl      = 1'($urandom_range(0, 1));
      if (rst) begin
        m_isr = 8'h00; m_last = 3'd0; m_p1 = 1'b1; m_p2 = 1'b1;
      end else begin
        r1  = ack1 && !m_p1;
        r2  = ack2 && !m_p2;
        nxt = m_isr;
        if (r2 && aeoi) nxt[m_last] = 1'b0;
        if (eoi) begin
          if (spec_flag) nxt[spec_irq] = 1'b0;
          else begin
            for (int i = 0; i < 8; i++) begin
              if (m_isr[i]) begin
                nxt[i] = 1'b0;
                break;
              end
            end
          end
        end
        if (r1) begin
          nxt[hpi] = 1'b1;
          m_last   = hpi;
        end
        m_isr = nxt;
        m_p1  = ack1;
        m_p2  = ack2;
      end
      cyc("rnd", m_isr, m_last);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/isr_unit.md
ISR_UNIT -- requirements
Module: isr_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk input 1 (rising edge samples everything); rst input 1 (synchronous, active-high).
REQ-002 highest_priority_idx  input  3  IR index (0..7) chosen by the priority resolver for the current acknowledge.
REQ-003 AEOI  input  1  automatic-EOI mode enable (level, ICW4).
REQ-004 specific_eoi_flag  input  1  1 = EOI command is specific, 0 = non-specific (qualified by eoi_cmd).
REQ-005 specific_irq  input  3  IR index to clear on a specific EOI.
REQ-006 eoi_cmd  input  1  one-cycle strobe: OCW2 EOI command issued.
REQ-007 ack1  input  1  first INTA pulse (level, active-high, may last several cycles).
REQ-008 ack2  input  1  second INTA pulse (level, active-high, may last several cycles).
REQ-009 SP  input  1  cascade role: 1 = master, 0 = slave; ignored when SNGL=1.
REQ-010 SNGL  input  1  1 = single PIC, 0 = cascade mode.
REQ-011 interrupts_in_service  output  8  registered ISR bit vector; bit n = IRn in service.
REQ-012 last_serviced_idx  output  3  registered index latched at the most recent ack1 rising edge.

Function
REQ-013 ack1 and ack2 SHALL be edge-detected internally (registered previous value); only the 0->1 transition acts, once per pulse.
REQ-014 On an ack1 rising edge the ISR bit highest_priority_idx SHALL be set and last_serviced_idx SHALL load highest_priority_idx; both outputs update on the same clock edge.
REQ-015 On an ack2 rising edge with AEOI=1 the ISR bit last_serviced_idx SHALL be cleared; with AEOI=0, ack2 SHALL have no effect.
REQ-016 On eoi_cmd=1 with specific_eoi_flag=1 the ISR bit specific_irq SHALL be cleared, whether or not it is set.
REQ-017 On eoi_cmd=1 with specific_eoi_flag=0 the lowest-numbered set ISR bit SHALL be cleared (fixed priority, IR0 highest); if ISR=0, nothing changes.
REQ-018 Set/clear rules SHALL be identical in single, cascade-master and cascade-slave modes; SP and SNGL SHALL not alter ISR contents.
REQ-019 Simultaneous events in one cycle: all clears (AEOI, EOI) SHALL be computed from the current ISR value, then the ack1 set is applied; if set and clear target the same bit, set wins.
REQ-020 Setting an already-set bit SHALL leave it set; other bits SHALL be unaffected by any single set or clear.
REQ-021 An ack2 rising edge with no preceding ack1 SHALL still act on the current last_serviced_idx.
REQ-022 Outputs SHALL change only on the clk rising edge; there is no combinational path from inputs to outputs.

Reset
REQ-023 While rst=1 at a clk edge: interrupts_in_service = 8'h00, last_serviced_idx = 3'b000, and ack edge-detect history = 0.
REQ-024 rst SHALL override all events in the same cycle; an ack pulse spanning the release of reset SHALL NOT be seen as a rising edge.

Structure
REQ-025 A shared package SHALL hold the IR count (8), the index width (3) and a lowest-set-bit priority function.
REQ-026 A single sub-module, pic_edge_detect (1-bit rising-edge detector), SHALL be instantiated once each for ack1 and ack2; all other logic is flat.

Verification
REQ-027 Reset then idle -> interrupts_in_service=00000000, last_serviced_idx=000.
REQ-028 AEOI=0, highest_priority_idx=3, ack1 pulse (3 cycles) then ack2 pulse -> ISR=00001000 after ack1 and still after ack2; last_serviced_idx=011; one set only.
REQ-029 AEOI=1, highest_priority_idx=1, ack1 then ack2 -> ISR=00000010 after ack1, 00000000 after the ack2 edge; last_serviced_idx=001.
REQ-030 ISR=00010100 (IR2 and IR4 serviced); eoi_cmd with specific_eoi_flag=0 -> 00010000; then eoi_cmd with specific_eoi_flag=1, specific_irq=4 -> 00000000.
REQ-031 SNGL=0, SP=0 then SP=1: repeat REQ-028 and REQ-029 with indices 2 and 4 -> identical results to single mode.
REQ-032 Same cycle: ack1 edge with idx=2 and eoi_cmd specific, specific_irq=2, ISR=00000100 -> ISR stays 00000100 (set wins); reset asserted mid-ack1 pulse -> all outputs 0, no set after release.
